// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, 3x3 window, 2-cycle pipeline.
// Magnitude is mode-selected and clamped to the pixel range.
module sobel_stream #(
  parameter int PW    = 8,
  parameter int IMG_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [PW-1:0] in_pix,
  input  logic [1:0]    mode,
  output logic          out_valid,
  output logic          out_sof,
  output logic [PW-1:0] out_pix
);

  localparam int CW = $clog2(IMG_W);
  localparam int GW = PW + 4;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [GW-1:0] MAX_PIX  = {4'b0000, {PW{1'b1}}};

  logic [CW-1:0] r_col;
  logic [1:0]    r_row;
  logic          r_sofSent;
  logic [PW-1:0] r_lb1 [IMG_W];
  logic [PW-1:0] r_lb2 [IMG_W];
  logic [PW-1:0] r_p0, r_p1, r_p3, r_p4, r_p6, r_p7;

  logic                 r_v1, r_sof1;
  logic [1:0]           r_mode1;
  logic signed [GW-1:0] r_gx, r_gy;

  logic [CW-1:0]        w_col;
  logic [1:0]           w_row;
  logic [PW-1:0]        w_d1, w_d2;
  logic                 w_qual;
  logic signed [GW-1:0] w_gx, w_gy;
  logic [GW-1:0]        w_ax, w_ay, w_mag;
  logic [PW-1:0]        w_clamp;

  function automatic logic signed [GW-1:0] ext(input logic [PW-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  // A start-of-frame beat is position (0,0) no matter where the counters were.
  always_comb begin
    w_col  = in_sof ? '0 : r_col;
    w_row  = in_sof ? 2'd0 : r_row;
    w_d1   = r_lb1[w_col];
    w_d2   = r_lb2[w_col];
    w_qual = in_valid && (w_row == 2'd2) && (w_col >= CW'(2));
  end

  // Newest window column (p2, p5, p8) comes straight from the line buffers and input.
  always_comb begin
    w_gx = (ext(w_d2) + (ext(w_d1) <<< 1) + ext(in_pix))
         - (ext(r_p0) + (ext(r_p3) <<< 1) + ext(r_p6));
    w_gy = (ext(r_p0) + (ext(r_p1) <<< 1) + ext(w_d2))
         - (ext(r_p6) + (ext(r_p7) <<< 1) + ext(in_pix));
  end

  always_comb begin
    w_ax  = r_gx[GW-1] ? -r_gx : r_gx;
    w_ay  = r_gy[GW-1] ? -r_gy : r_gy;
    w_mag = w_ax + w_ay;
    case (r_mode1)
      2'b01:   w_mag = (w_ax > w_ay) ? w_ax : w_ay;
      2'b10:   w_mag = w_ax;
      2'b11:   w_mag = w_ay;
      default: w_mag = w_ax + w_ay;
    endcase
    w_clamp = (w_mag > MAX_PIX) ? {PW{1'b1}} : w_mag[PW-1:0];
  end

  // Line buffers are deliberately unreset; row gating hides stale contents.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_lb1[w_col] <= in_pix;
      r_lb2[w_col] <= w_d1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= 2'd0;
      r_sofSent <= 1'b0;
      r_p0 <= '0; r_p1 <= '0; r_p3 <= '0;
      r_p4 <= '0; r_p6 <= '0; r_p7 <= '0;
    end else if (in_valid) begin
      if (w_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
      if (w_qual)
        r_sofSent <= 1'b1;
      else if (in_sof)
        r_sofSent <= 1'b0;
      r_p0 <= r_p1; r_p1 <= w_d2;
      r_p3 <= r_p4; r_p4 <= w_d1;
      r_p6 <= r_p7; r_p7 <= in_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_sof1    <= 1'b0;
      r_mode1   <= 2'b00;
      r_gx      <= '0;
      r_gy      <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_pix   <= '0;
    end else begin
      r_v1      <= w_qual;
      r_sof1    <= w_qual && !r_sofSent;
      r_mode1   <= mode;
      r_gx      <= w_gx;
      r_gy      <= w_gy;
      out_valid <= r_v1;
      out_sof   <= r_sof1;
      out_pix   <= r_v1 ? w_clamp : '0;
    end
  end

endmodule
